// File: rtl/mprjram_pkg.sv
// ---------------------------------------------------------------------------
// mprjram_pkg
// Shared definitions for the user-project BRAM (mprjram) arbiter:
//   - arbiter FSM state encoding
//   - CPU window base address of the BRAM
//   - default geometry / latency constants used as parameter defaults
// ---------------------------------------------------------------------------
package mprjram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

   localparam logic [31:0] MPRJRAM_BASE   = 32'h3800_0000;
   localparam int          MPRJRAM_ADDR_W = 10;
   localparam int          MPRJRAM_DATA_W = 32;
   localparam int          MPRJRAM_RD_LAT = 1;

   // Latency counter width; covers the legal RD_LAT range 1..15.
   localparam int          MPRJRAM_CNT_W  = 4;

endpackage

// File: rtl/mprjram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   i_req        [1:0] request vector (bit 0 = requester 0, bit 1 = requester 1)
//   i_last_grant       index of the requester granted most recently
//   o_grant            index of the selected requester (valid when o_any)
//   o_any              at least one request is pending
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic       o_grant,
   output logic       o_any
);

   always_comb begin
      o_any   = |i_req;
      o_grant = 1'b0;
      if (i_req == 2'b11) begin
         // Contention: the requester not served last time wins.
         o_grant = ~i_last_grant;
      end else begin
         // Single (or no) request: bit 1 set means requester 1.
         o_grant = i_req[1];
      end
   end

endmodule

// File: rtl/mprjram_arbiter.sv
// ---------------------------------------------------------------------------
// mprjram_arbiter
// Shares the single user-project BRAM between the Wishbone path (requester 0)
// and a user-side master (requester 1). One access at a time, round-robin
// under contention, fixed-latency BRAM port, one ack pulse per access.
// Ports:
//   axis_clk / axis_rst_n   clock, synchronous active-low reset
//   rN_req/we/sel/addr/wdata  requester N access (req held until rN_ack)
//   rN_ack / rN_rdata       completion pulse and read data for requester N
//   bram_en/we/addr/wdata   BRAM access strobe and write-side signals
//   bram_rdata              BRAM read data, valid RD_LAT cycles after bram_en
//   busy                    high whenever the FSM is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module mprjram_arbiter #(
   parameter int ADDR_W = mprjram_pkg::MPRJRAM_ADDR_W,
   parameter int DATA_W = mprjram_pkg::MPRJRAM_DATA_W,
   parameter int RD_LAT = mprjram_pkg::MPRJRAM_RD_LAT
) (
   input  logic                axis_clk,
   input  logic                axis_rst_n,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [DATA_W/8-1:0] r0_sel,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   output logic                r0_ack,
   output logic [DATA_W-1:0]   r0_rdata,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [DATA_W/8-1:0] r1_sel,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   output logic                r1_ack,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                bram_en,
   output logic [DATA_W/8-1:0] bram_we,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [DATA_W-1:0]   bram_wdata,
   input  logic [DATA_W-1:0]   bram_rdata,
   output logic                busy
);

   import mprjram_pkg::*;

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = MPRJRAM_CNT_W;

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_dec;
   logic                r_owner;
   logic                r_last_grant;
   logic                r_bram_en;
   logic [SEL_W-1:0]    r_bram_we;
   logic [ADDR_W-1:0]   r_bram_addr;
   logic [DATA_W-1:0]   r_bram_wdata;
   logic                r_r0_ack;
   logic                r_r1_ack;
   logic [DATA_W-1:0]   r_r0_rdata;
   logic [DATA_W-1:0]   r_r1_rdata;
   logic                r_busy;

   logic                w_grant;
   logic                w_any;
   logic                w_we;
   logic [SEL_W-1:0]    w_sel;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;

   rr_arb2 u_rr_arb2 (
      .i_req        ({r1_req, r0_req}),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_any        (w_any)
   );

   // Request fields of whichever requester the picker selects.
   assign w_we      = w_grant ? r1_we    : r0_we;
   assign w_sel     = w_grant ? r1_sel   : r0_sel;
   assign w_addr    = w_grant ? r1_addr  : r0_addr;
   assign w_wdata   = w_grant ? r1_wdata : r0_wdata;

   assign w_cnt_dec = r_cnt - CNT_W'(1);

   // FSM state register.
   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic. Requests are only looked at in IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next_state = ISSUE;
         ISSUE:   w_next_state = WAIT;
         WAIT:    if (w_cnt_dec == '0) w_next_state = ACK;
         ACK:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Registered outputs, latched request and latency counter. The BRAM
   // address/data registers double as the latched request fields; they are
   // loaded on the IDLE->ISSUE edge so bram_en/bram_we line up with ISSUE.
   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         r_cnt        <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_bram_en    <= 1'b0;
         r_bram_we    <= '0;
         r_bram_addr  <= '0;
         r_bram_wdata <= '0;
         r_r0_ack     <= 1'b0;
         r_r1_ack     <= 1'b0;
         r_r0_rdata   <= '0;
         r_r1_rdata   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_bram_en <= 1'b0;
         r_bram_we <= '0;
         r_r0_ack  <= 1'b0;
         r_r1_ack  <= 1'b0;
         r_busy    <= (w_next_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner      <= w_grant;
                  r_bram_en    <= 1'b1;
                  r_bram_we    <= w_we ? w_sel : '0;
                  r_bram_addr  <= w_addr;
                  r_bram_wdata <= w_wdata;
               end
            end
            ISSUE: begin
               r_cnt <= CNT_W'(RD_LAT);
            end
            WAIT: begin
               r_cnt <= w_cnt_dec;
               // Writes take the same path; whatever the BRAM returns is
               // captured but carries no meaning for the requester.
               if (w_cnt_dec == '0) begin
                  if (r_owner) begin
                     r_r1_rdata <= bram_rdata;
                     r_r1_ack   <= 1'b1;
                  end else begin
                     r_r0_rdata <= bram_rdata;
                     r_r0_ack   <= 1'b1;
                  end
               end
            end
            ACK: begin
               r_last_grant <= r_owner;
            end
            default: ;
         endcase
      end
   end

   assign bram_en    = r_bram_en;
   assign bram_we    = r_bram_we;
   assign bram_addr  = r_bram_addr;
   assign bram_wdata = r_bram_wdata;
   assign r0_ack     = r_r0_ack;
   assign r1_ack     = r_r1_ack;
   assign r0_rdata   = r_r0_rdata;
   assign r1_rdata   = r_r1_rdata;
   assign busy       = r_busy;

endmodule

// File: tb/tb_mprjram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mprjram_arbiter
// Directed bench for mprjram_arbiter. Instance A uses RD_LAT=1, instance B
// uses RD_LAT=4; each drives its own behavioural BRAM model.
// ---------------------------------------------------------------------------
module tb_mprjram_arbiter;

   import mprjram_pkg::*;

   localparam logic [31:0] CPU_LO  = MPRJRAM_BASE + 32'h0000_0040;
   localparam logic [31:0] CPU_HI  = MPRJRAM_BASE + 32'h0000_0FFC;
   localparam logic [9:0]  ADDR_LO = 10'((CPU_LO - MPRJRAM_BASE) >> 2);
   localparam logic [9:0]  ADDR_HI = 10'((CPU_HI - MPRJRAM_BASE) >> 2);

   logic        clk;
   logic        rst_n;

   // Instance A signals (RD_LAT = 1)
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [3:0]  r0_sel, r1_sel;
   logic [9:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic        r0_ack, r1_ack;
   logic [31:0] r0_rdata, r1_rdata;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_wdata, bram_rdata;
   logic        busy;

   // Instance B signals (RD_LAT = 4); requester 1 stays idle.
   logic        b_r0_req, b_r0_we;
   logic [3:0]  b_r0_sel;
   logic [9:0]  b_r0_addr;
   logic [31:0] b_r0_wdata;
   logic        b_r0_ack, b_r1_ack;
   logic [31:0] b_r0_rdata, b_r1_rdata;
   logic        b_bram_en;
   logic [3:0]  b_bram_we;
   logic [9:0]  b_bram_addr;
   logic [31:0] b_bram_wdata, b_bram_rdata;
   logic        b_busy;

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   mprjram_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_dut_a (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_sel(r0_sel), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_sel(r1_sel), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
   );

   mprjram_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(4)) u_dut_b (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_sel(b_r0_sel), .r0_addr(b_r0_addr),
      .r0_wdata(b_r0_wdata), .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
      .r1_req(1'b0), .r1_we(1'b0), .r1_sel(4'h0), .r1_addr(10'h000),
      .r1_wdata(32'h0), .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
      .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
      .bram_wdata(b_bram_wdata), .bram_rdata(b_bram_rdata), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model A: read-first, one register stage of read latency.
   logic [31:0] mem_a [0:1023];
   logic [31:0] pipe_a;
   always @(posedge clk) begin
      if (bram_en) begin
         for (int k = 0; k < 4; k++)
            if (bram_we[k]) mem_a[bram_addr][8*k +: 8] <= bram_wdata[8*k +: 8];
         pipe_a <= mem_a[bram_addr];
      end
   end
   assign bram_rdata = pipe_a;

   // BRAM model B: read-first, four register stages of read latency.
   logic [31:0] mem_b [0:1023];
   logic [31:0] pipe_b [4];
   always @(posedge clk) begin
      if (b_bram_en) begin
         for (int k = 0; k < 4; k++)
            if (b_bram_we[k]) mem_b[b_bram_addr][8*k +: 8] <= b_bram_wdata[8*k +: 8];
         pipe_b[0] <= mem_b[b_bram_addr];
      end
      for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
   end
   assign b_bram_rdata = pipe_b[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on instance A: checks ack latency (3), single bram_en,
   // no ack to the other requester, and optionally the returned data.
   task automatic acc_a(input bit p, input bit we, input logic [3:0] sel,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input bit chk_rd, input logic [31:0] exp_rd, input string tag);
      int          n;
      int          en_cnt;
      bit          got;
      bit          other;
      logic [31:0] rd;
      n = 0; en_cnt = 0; got = 0; other = 0; rd = '0;
      if (!p) begin
         r0_we = we; r0_sel = sel; r0_addr = addr; r0_wdata = wd; r0_req = 1'b1;
      end else begin
         r1_we = we; r1_sel = sel; r1_addr = addr; r1_wdata = wd; r1_req = 1'b1;
      end
      while (!got && n < 20) begin
         tick();
         n++;
         if (bram_en) en_cnt++;
         if (p ? r0_ack : r1_ack) other = 1'b1;
         if (p ? r1_ack : r0_ack) begin
            got = 1'b1;
            rd  = p ? r1_rdata : r0_rdata;
         end
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk({tag, "_ack_lat"}, 32'(n), 32'd3);
      chk({tag, "_en_cycles"}, 32'(en_cnt), 32'd1);
      chk({tag, "_other_ack"}, {31'b0, other}, 32'd0);
      if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
      tick();
   endtask

   // One r0 access on instance B (RD_LAT=4): ack at 6, busy high 1..6, low at 7.
   task automatic acc_b(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                        input bit chk_rd, input logic [31:0] exp_rd, input string tag);
      int          n;
      bit          got;
      bit          busy_bad;
      logic [31:0] rd;
      n = 0; got = 0; busy_bad = 0; rd = '0;
      b_r0_we = we; b_r0_sel = 4'hF; b_r0_addr = addr; b_r0_wdata = wd; b_r0_req = 1'b1;
      while (!got && n < 20) begin
         tick();
         n++;
         if (!b_busy) busy_bad = 1'b1;
         if (b_r0_ack) begin
            got = 1'b1;
            rd  = b_r0_rdata;
         end
      end
      b_r0_req = 1'b0;
      chk({tag, "_ack_lat"}, 32'(n), 32'd6);
      chk({tag, "_busy_during"}, {31'b0, busy_bad}, 32'd0);
      if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
      tick();
      chk({tag, "_busy_after"}, {31'b0, b_busy}, 32'd0);
   endtask

   initial begin
      int   nack;
      int   c0;
      int   c1;
      int   n;
      bit   both;
      logic [31:0] hold;

      rst_n = 1'b0;
      r0_req = 0; r0_we = 0; r0_sel = 4'hF; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_sel = 4'hF; r1_addr = '0; r1_wdata = '0;
      b_r0_req = 0; b_r0_we = 0; b_r0_sel = 4'hF; b_r0_addr = '0; b_r0_wdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_bram_en", {31'b0, bram_en}, 32'd0);
      chk("rst_bram_we", {28'b0, bram_we}, 32'd0);
      chk("rst_bram_addr", {22'b0, bram_addr}, 32'd0);
      chk("rst_bram_wdata", bram_wdata, 32'd0);
      chk("rst_r0_ack", {31'b0, r0_ack}, 32'd0);
      chk("rst_r1_ack", {31'b0, r1_ack}, 32'd0);
      chk("rst_r0_rdata", r0_rdata, 32'd0);
      chk("rst_r1_rdata", r1_rdata, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_b_busy", {31'b0, b_busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single read: r1 writes the pattern, r0 reads it back
      acc_a(1'b1, 1'b1, 4'hF, ADDR_LO, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr_lo");
      chk("mem_lo", mem_a[ADDR_LO], 32'hDEAD_BEEF);
      acc_a(1'b0, 1'b0, 4'hF, ADDR_LO, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_lo");

      // Byte write at the top address
      acc_a(1'b0, 1'b1, 4'hF, ADDR_HI, 32'h1111_1111, 1'b0, 32'h0, "wr_hi_full");
      acc_a(1'b1, 1'b1, 4'b0010, ADDR_HI, 32'h0000_AB00, 1'b0, 32'h0, "wr_hi_byte");
      chk("mem_hi", mem_a[ADDR_HI], 32'h1111_AB11);
      acc_a(1'b0, 1'b0, 4'hF, ADDR_HI, 32'h0, 1'b1, 32'h1111_AB11, "rd_hi");
      hold = r0_rdata;
      acc_a(1'b1, 1'b0, 4'hF, ADDR_LO, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_lo_r1");
      chk("r0_rdata_hold", r0_rdata, hold);

      // Contention after reset: strict alternation starting with r0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r0_we = 0; r0_addr = ADDR_LO; r1_we = 0; r1_addr = ADDR_HI;
      r0_req = 1'b1; r1_req = 1'b1;
      nack = 0; c0 = 0; c1 = 0; n = 0; both = 0;
      while (nack < 8 && n < 60) begin
         tick();
         n++;
         if (r0_ack && r1_ack) both = 1'b1;
         if (r0_ack) begin
            chk($sformatf("cont_order%0d", nack), 32'd0, 32'(nack % 2));
            chk($sformatf("cont_edge%0d", nack), 32'(n), 32'(3 + 4*nack));
            chk($sformatf("cont_rd%0d", nack), r0_rdata, 32'hDEAD_BEEF);
            c0++;
            if (c0 == 4) r0_req = 1'b0;
            nack++;
         end else if (r1_ack) begin
            chk($sformatf("cont_order%0d", nack), 32'd1, 32'(nack % 2));
            chk($sformatf("cont_edge%0d", nack), 32'(n), 32'(3 + 4*nack));
            chk($sformatf("cont_rd%0d", nack), r1_rdata, 32'h1111_AB11);
            c1++;
            if (c1 == 4) r1_req = 1'b0;
            nack++;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      chk("cont_acks", 32'(nack), 32'd8);
      chk("cont_both", {31'b0, both}, 32'd0);
      tick();

      // Reset mid-access: r0 served last, then r1 is cut off in WAIT
      acc_a(1'b0, 1'b0, 4'hF, ADDR_LO, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_pre_rst");
      r1_we = 0; r1_addr = ADDR_HI; r1_req = 1'b1;
      tick(); tick();
      chk("mid_busy_wait", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_ack", {30'b0, r1_ack, r0_ack}, 32'd0);
      chk("mid_rst_en", {31'b0, bram_en}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      r0_we = 0; r0_addr = ADDR_HI; r0_req = 1'b1;
      nack = 0; n = 0;
      while (nack < 2 && n < 30) begin
         tick();
         n++;
         if (r0_ack) begin
            chk("post_rst_first", {31'b0, nack == 0}, 32'd1);
            chk("post_rst_r0_edge", 32'(n), 32'd3);
            chk("post_rst_r0_rd", r0_rdata, 32'h1111_AB11);
            r0_req = 1'b0;
            nack++;
         end
         if (r1_ack) begin
            chk("post_rst_r1_edge", 32'(n), 32'd7);
            chk("post_rst_r1_rd", r1_rdata, 32'h1111_AB11);
            r1_req = 1'b0;
            nack++;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      chk("post_rst_acks", 32'(nack), 32'd2);
      tick();

      // RD_LAT = 4 instance
      acc_b(1'b1, 10'h005, 32'hCAFE_F00D, 1'b0, 32'h0, "b_wr");
      chk("b_mem", mem_b[10'h005], 32'hCAFE_F00D);
      acc_b(1'b0, 10'h005, 32'h0, 1'b1, 32'hCAFE_F00D, "b_rd");
      chk("b_r1_ack", {31'b0, b_r1_ack}, 32'd0);
      chk("b_r1_rdata", b_r1_rdata, 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
